// File: rtl/ready_timer_pkg.sv
// Shared types and default widths for the ready_timer block.
package ready_timer_pkg;

  localparam int DLY_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_READY = 2'd2
  } state_e;

endpackage

// File: rtl/ready_timer.sv
// Delayed-ready event timer: after a start it counts down a programmable delay,
// then presents ready until it is acknowledged or the event is aborted.
module ready_timer
  import ready_timer_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DLY_W-1:0] delay,
  input  logic             ack,
  input  logic             abort,
  input  logic             clr_ovr,
  output logic             ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             ovr_set;
  logic [DLY_W-1:0] load_val;

  // A zero delay behaves as one cycle so ready never coincides with acceptance.
  assign load_val = (delay == '0) ? DLY_W'(1) : delay;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    ovr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = load_val;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          ovr_set = start;
          if (cnt_q <= DLY_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_READY;
          end else begin
            cnt_d = cnt_q - DLY_W'(1);
          end
        end
      end
      ST_READY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          done_d = done_q + CNT_W'(1);
          if (start) begin
            cnt_d   = load_val;
            state_d = ST_COUNT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ovr_set = start;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    // Setting wins over a simultaneous clear.
    ovr_d = (ovr_q & ~clr_ovr) | ovr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ready      = (state_q == ST_READY);
  assign busy       = (state_q != ST_IDLE);
  assign done_count = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ready_timer.sv
// Self-checking bench for ready_timer: expected ready-rise cycles are queued at start
// and compared when ready is observed.
module tb_ready_timer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] delay;
  logic        ack;
  logic        abort;
  logic        clr_ovr;
  logic        ready;
  logic        busy;
  logic [7:0]  done_count;
  logic        overrun;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          exp_q[$];
  logic [7:0]  exp_done = 8'd0;

  ready_timer #(.DLY_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .delay(delay), .ack(ack),
    .abort(abort), .clr_ovr(clr_ovr), .ready(ready), .busy(busy),
    .done_count(done_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_start(input logic [15:0] d);
    start = 1'b1;
    delay = d;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(cyc + ((d == 16'd0) ? 1 : int'(d)));
  endtask

  task automatic wait_ready(output int seen);
    int n;
    seen = -1;
    n = 0;
    while (n < 300 && seen < 0) begin
      if (ready === 1'b1) seen = cyc;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    exp_done = exp_done + 8'd1;
  endtask

  task automatic pop_exp(output int e);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
  endtask

  task automatic test_reset();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done_count !== 8'd0) begin bad++; $display("FAIL reset_done got=%0d want=0", done_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
  endtask

  task automatic test_basic();
    int seen, e;
    drive_start(16'd20);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL basic_rise got=%0d want=%0d", seen, e); end
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_hold1 got=%b want=1", ready); end
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_hold2 got=%b want=1", ready); end
    do_ack();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL basic_fall got=%b want=0", ready); end
    total++; if (done_count !== exp_done) begin bad++; $display("FAIL basic_done got=%0d want=%0d", done_count, exp_done); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL basic_ovr got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", busy); end
  endtask

  task automatic test_min_delay();
    int seen, e;
    logic [15:0] dv;
    for (int i = 0; i < 2; i++) begin
      dv = 16'(i);
      drive_start(dv);
      wait_ready(seen);
      pop_exp(e);
      total++; if (seen !== e) begin bad++; $display("FAIL min_delay_rise d=%0d got=%0d want=%0d", i, seen, e); end
      do_ack();
      total++; if (done_count !== exp_done) begin bad++; $display("FAIL min_delay_done got=%0d want=%0d", done_count, exp_done); end
    end
  endtask

  task automatic test_overrun();
    int seen, e;
    drive_start(16'd10);
    repeat (4) @(negedge clk);
    start = 1'b1;
    delay = 16'd3;
    @(negedge clk);
    start = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL ovr_rise got=%0d want=%0d", seen, e); end
    // start while presenting without ack also counts as overrun and is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ovr_ready_hold got=%b want=1", ready); end
    do_ack();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovr_ignored got=%b want=0", busy); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", overrun); end
  endtask

  task automatic test_back_to_back();
    int seen, e;
    drive_start(16'd4);
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL b2b_rise1 got=%0d want=%0d", seen, e); end
    start = 1'b1;
    ack = 1'b1;
    delay = 16'd4;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    exp_done = exp_done + 8'd1;
    exp_q.push_back(cyc + 4);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b want=0", ready); end
    total++; if (done_count !== exp_done) begin bad++; $display("FAIL b2b_done got=%0d want=%0d", done_count, exp_done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b want=0", overrun); end
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL b2b_rise2 got=%0d want=%0d", seen, e); end
    do_ack();
  endtask

  task automatic test_abort();
    int seen, e;
    drive_start(16'd3);
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL abort_rise got=%0d want=%0d", seen, e); end
    abort = 1'b1;
    ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ack = 1'b0;
    start = 1'b0;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done_count !== exp_done) begin bad++; $display("FAIL abort_done got=%0d want=%0d", done_count, exp_done); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL abort_ovr got=%b want=0", overrun); end
    drive_start(16'd6);
    void'(exp_q.pop_back());
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_count got=%b want=0", busy); end
    // abort in IDLE must not block a start
    abort = 1'b1;
    drive_start(16'd2);
    abort = 1'b0;
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL abort_idle_rise got=%0d want=%0d", seen, e); end
    do_ack();
  endtask

  task automatic test_wrap();
    int seen, e;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_done = 8'd0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      drive_start(16'd1);
      wait_ready(seen);
      pop_exp(e);
      if (seen !== e) begin bad++; $display("FAIL wrap_rise i=%0d got=%0d want=%0d", i, seen, e); end
      total++;
      do_ack();
      if (i == 254) begin
        total++; if (done_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d want=255", done_count); end
      end
    end
    total++; if (done_count !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", done_count); end
  endtask

  task automatic test_async_reset();
    int seen, e;
    drive_start(16'd1);
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL ar_pre_rise got=%0d want=%0d", seen, e); end
    do_ack();
    drive_start(16'd10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (overrun !== 1'b1 || done_count !== 8'd1) begin bad++; $display("FAIL ar_setup got=%b/%0d want=1/1", overrun, done_count); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b want=0", busy); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL ar_ready got=%b want=0", ready); end
    total++; if (done_count !== 8'd0) begin bad++; $display("FAIL ar_done got=%0d want=0", done_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ar_ovr got=%b want=0", overrun); end
    exp_q.delete();
    exp_done = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_start(16'd3);
    wait_ready(seen);
    pop_exp(e);
    total++; if (seen !== e) begin bad++; $display("FAIL ar_post_rise got=%0d want=%0d", seen, e); end
    do_ack();
    total++; if (done_count !== exp_done) begin bad++; $display("FAIL ar_post_done got=%0d want=%0d", done_count, exp_done); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    delay = 16'd0;
    ack = 1'b0;
    abort = 1'b0;
    clr_ovr = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_min_delay();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ready_timer.md
READY_TIMER -- requirements
Module: ready_timer

Interface
REQ-001 Parameter DLY_W, default 16, width of the delay load value and internal down-counter.
REQ-002 Parameter CNT_W, default 8, width of the completed-event counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a timed ready event; sampled only when accepted per REQ-013/REQ-018.
REQ-006 delay  input  DLY_W  cycles from start acceptance to ready assertion; sampled with an accepted start.
REQ-007 ack  input  1  consumer acknowledge of ready.
REQ-008 abort  input  1  cancel the pending or presented event.
REQ-009 clr_ovr  input  1  clear the sticky overrun flag.
REQ-010 ready  output  1  level, high while the event is presented to the consumer.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done_count  output  CNT_W  count of events completed by ack; overrun  output  1  sticky start-while-busy flag.

Function
REQ-013 States IDLE, COUNT, READY; in IDLE, start=1 SHALL load the counter with max(delay,1) and enter COUNT.
REQ-014 In COUNT the counter SHALL decrement by 1 per cycle; when counter==1 the next state SHALL be READY.
REQ-015 ready SHALL rise exactly max(delay,1) cycles after the edge that accepted start, with no combinational path from any input.
REQ-016 In READY, ready SHALL hold high until ack=1 is sampled; then ready falls on that edge and done_count increments by 1, wrapping from 2^CNT_W-1 to 0.
REQ-017 ack with no start in the same cycle SHALL return the state to IDLE; ack outside READY SHALL be ignored.
REQ-018 start and ack in the same READY cycle SHALL complete the current event (increment) and accept the new one: load max(delay,1), enter COUNT, overrun unchanged.
REQ-019 start in COUNT, or in READY without ack, SHALL be ignored and SHALL set overrun.
REQ-020 abort in COUNT or READY SHALL return to IDLE next edge, drop ready, and not increment done_count; abort overrides ack and start in the same cycle; abort in IDLE has no effect.
REQ-021 clr_ovr SHALL clear overrun; if clr_ovr and a setting condition occur in the same cycle, overrun SHALL end set.
REQ-022 busy SHALL be a registered-state decode: 1 in COUNT and READY, 0 in IDLE.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, counter 0, ready 0, busy 0, done_count 0, overrun 0, regardless of clk.
REQ-024 Reset asserted mid-COUNT or mid-READY SHALL discard the event; after release the block SHALL accept start on the first rising edge.

Structure
REQ-025 Package ready_timer_pkg SHALL hold the state enum typedef and the DLY_W/CNT_W default constants.
REQ-026 No sub-module; counter, FSM and flags SHALL live in ready_timer.

Verification
REQ-027 delay=20, start at edge k, ack 3 cycles after ready -> ready high edges k+20..k+23, done_count=1, overrun=0.
REQ-028 delay=0 and delay=1 -> ready rises exactly 1 cycle after start in both cases.
REQ-029 start again at cycle 5 of a delay=10 COUNT -> event unaffected, ready at k+10, overrun=1; clr_ovr pulse -> overrun=0.
REQ-030 start+ack same READY cycle with delay=4 -> done_count+1, ready low next cycle, ready again 4 cycles after that edge.
REQ-031 abort+ack same READY cycle -> IDLE, done_count unchanged; 256 completed events with CNT_W=8 -> done_count=0.
REQ-032 rst_n pulsed low between edges mid-COUNT -> all outputs 0 immediately; new start delay=3 after release -> ready at +3.
